// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator result path: result bit positions,
// legal one-hot result codes and the monitor FSM encoding.
package comparator_pkg;

  localparam int R_GT = 2;
  localparam int R_EQ = 1;
  localparam int R_LT = 0;

  localparam logic [2:0] R_CODE_GT = 3'b100;
  localparam logic [2:0] R_CODE_EQ = 3'b010;
  localparam logic [2:0] R_CODE_LT = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one; it holds
// at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         ld1,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // clr beats ld1, which beats inc
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld1) begin
      q_d = W'(1);
    end else if (inc && (q_q != MAX)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/comparator_result_monitor.sv
// Registers comparator results with their operands, keeps saturating outcome
// and run-length statistics, and latches a fault on illegal or wrong results.
module comparator_result_monitor
  import comparator_pkg::*;
#(
  parameter int N          = 4,
  parameter int CNT_W      = 8,
  parameter int RUN_THRESH = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  input  logic             CLR,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [2:0]       R,
  output logic             OUT_VALID,
  output logic [N-1:0]     A_Q,
  output logic [N-1:0]     B_Q,
  output logic [2:0]       R_Q,
  output logic [CNT_W-1:0] GT_CNT,
  output logic [CNT_W-1:0] EQ_CNT,
  output logic [CNT_W-1:0] LT_CNT,
  output logic [CNT_W-1:0] RUN_LEN,
  output logic             STREAK,
  output logic             ERR
);

  state_e       state_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [2:0]   r_q;
  logic         out_valid_q;
  logic         err_q;

  logic [2:0] rel_code;
  logic       take;
  logic       accept;
  logic       same_run;

  // The expected code is recomputed from the operands, so an illegal code and
  // a legal-but-wrong code are caught by the same inequality.
  always_comb begin
    if (A > B) begin
      rel_code = R_CODE_GT;
    end else if (A == B) begin
      rel_code = R_CODE_EQ;
    end else begin
      rel_code = R_CODE_LT;
    end
  end

  assign take     = IN_VALID && !CLR && (state_q != ST_FAULT);
  assign accept   = take && (R == rel_code);
  assign same_run = (state_q == ST_RUN) && (R == r_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (CLR) begin
        state_q <= ST_IDLE;
        a_q     <= '0;
        b_q     <= '0;
        r_q     <= '0;
        err_q   <= 1'b0;
      end else if (take) begin
        if (R == rel_code) begin
          a_q         <= A;
          b_q         <= B;
          r_q         <= R;
          out_valid_q <= 1'b1;
          state_q     <= ST_RUN;
        end else begin
          err_q   <= 1'b1;
          state_q <= ST_FAULT;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (CLR),
    .inc   (accept && R[R_GT]),
    .ld1   (1'b0),
    .q     (GT_CNT)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (CLR),
    .inc   (accept && R[R_EQ]),
    .ld1   (1'b0),
    .q     (EQ_CNT)
  );

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (CLR),
    .inc   (accept && R[R_LT]),
    .ld1   (1'b0),
    .q     (LT_CNT)
  );

  // A new outcome (or the first after idle) restarts the run at one.
  sat_counter #(.W(CNT_W)) u_run_len (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (CLR),
    .inc   (accept && same_run),
    .ld1   (accept && !same_run),
    .q     (RUN_LEN)
  );

  assign STREAK    = (RUN_LEN >= CNT_W'(RUN_THRESH));
  assign OUT_VALID = out_valid_q;
  assign A_Q       = a_q;
  assign B_Q       = b_q;
  assign R_Q       = r_q;
  assign ERR       = err_q;

endmodule
